// File: rtl/proj_sweep_sequencer.sv
// Exhaustive sweep of an N_IN-input single-output cone: issues every input pattern,
// packs the sampled results into truth-table words, and keeps an onset count and CRC-16.
module proj_sweep_sequencer #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned LAT    = 0,
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   pat_o,
  input  logic              res_i,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] tt_data,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic [N_IN:0]     onset_cnt,
  output logic [15:0]       sig
);

  localparam int unsigned NPAT = 1 << N_IN;
  localparam int unsigned PW   = N_IN + 1;
  localparam int unsigned PK_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned CW   = $clog2(2 * WORD_W + LAT + 2) + 2;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [N_IN-1:0]   pat_q, pat_d;
  logic [LAT:0]      vld_q, vld_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [PK_W-1:0]   packed_q, packed_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] tail_q, tail_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic              tt_valid_q, tt_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_IN:0]     onset_q, onset_d;
  logic [15:0]       sig_q, sig_d;

  logic              issue;
  logic              push;
  logic              pop;
  logic              fb;
  logic              credit_ok;
  logic [CW-1:0]     inflight;
  logic [WORD_W-1:0] word_c;

  // Next-state, issue credit, result sampling and output FIFO
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    pat_d      = pat_q;
    vld_d      = '0;
    pack_d     = pack_q;
    packed_d   = packed_q;
    data_d     = data_q;
    tail_d     = tail_q;
    fcnt_d     = fcnt_q;
    onset_d    = onset_q;
    sig_d      = sig_q;
    issue      = 1'b0;
    push       = 1'b0;
    pop        = tt_valid_q & tt_ready;
    fb         = 1'b0;
    word_c     = '0;
    inflight   = '0;

    for (int unsigned i = 0; i <= LAT; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
    // Never commit more bits than the pack register plus free FIFO slots can hold
    credit_ok = (CW'(packed_q) + inflight + CW'(1)) <=
                (CW'(WORD_W) * (CW'(2) - CW'(fcnt_q)));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          p_d      = '0;
          onset_d  = '0;
          sig_d    = CRC_INIT;
          pack_d   = '0;
          packed_d = '0;
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          pat_d = p_q[N_IN-1:0];
          p_d   = p_q + PW'(1);
          if (p_q == PW'(NPAT - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (inflight == '0) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == 2'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    vld_d[0] = issue;
    for (int unsigned i = 1; i <= LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    // A token leaving the pipe marks res_i as the result of the oldest pattern in flight
    if (vld_q[LAT]) begin
      word_c          = pack_q;
      word_c[packed_q] = res_i;
      if (res_i) begin
        onset_d = onset_q + PW'(1);
      end
      fb    = sig_q[15] ^ res_i;
      sig_d = {sig_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      if (packed_q == PK_W'(WORD_W - 1)) begin
        push     = 1'b1;
        pack_d   = '0;
        packed_d = '0;
      end else begin
        pack_d   = word_c;
        packed_d = packed_q + PK_W'(1);
      end
    end

    // Two-entry FIFO: data_q is the head presented on tt_data, tail_q the second entry
    case ({push, pop})
      2'b10: begin
        if (fcnt_q == 2'd0) begin
          data_d = word_c;
        end else begin
          tail_d = word_c;
        end
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        if (fcnt_q == 2'd2) begin
          data_d = tail_q;
        end
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          data_d = word_c;
        end else begin
          data_d = tail_q;
          tail_d = word_c;
        end
      end
      default: begin
        fcnt_d = fcnt_q;
      end
    endcase

    tt_valid_d = (fcnt_d != 2'd0);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      pat_q      <= '0;
      vld_q      <= '0;
      pack_q     <= '0;
      packed_q   <= '0;
      data_q     <= '0;
      tail_q     <= '0;
      fcnt_q     <= 2'd0;
      tt_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      onset_q    <= '0;
      sig_q      <= CRC_INIT;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      pat_q      <= pat_d;
      vld_q      <= vld_d;
      pack_q     <= pack_d;
      packed_q   <= packed_d;
      data_q     <= data_d;
      tail_q     <= tail_d;
      fcnt_q     <= fcnt_d;
      tt_valid_q <= tt_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      onset_q    <= onset_d;
      sig_q      <= sig_d;
    end
  end

  assign pat_o     = pat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tt_data   = data_q;
  assign tt_valid  = tt_valid_q;
  assign onset_cnt = onset_q;
  assign sig       = sig_q;

  // The issue credit rule guarantees a full FIFO is only written when it is also popped
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fcnt_q == 2'd2) && !pop));

endmodule

// File: tb/tb_proj_sweep_sequencer.sv
// Bench for proj_sweep_sequencer: two instances (LAT=0 and LAT=3) swept against a
// truth-table/CRC reference model built from the cone function.
module tb_proj_sweep_sequencer;

  localparam int NPAT  = 256;
  localparam int NWORD = 32;
  localparam int RXMAX = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        start    = 1'b0;
  logic        tt_ready = 1'b1;
  logic [1:0]  res;
  logic [1:0]  busy, done, tt_valid;
  logic [7:0]  pat   [2];
  logic [7:0]  ttd   [2];
  logic [8:0]  onset [2];
  logic [15:0] sig   [2];

  logic [NPAT-1:0] cone_tt = '1;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;

  // LAT=0 cone is combinational; LAT=3 cone has three register stages
  assign res[0] = cone_tt[pat[0]];
  always @(posedge clk) begin
    s1 <= cone_tt[pat[1]];
    s2 <= s1;
    s3 <= s2;
  end
  assign res[1] = s3;

  proj_sweep_sequencer #(.N_IN(8), .LAT(0), .WORD_W(8)) u_dut_lat0 (
    .clk(clk), .rst(rst), .start(start), .pat_o(pat[0]), .res_i(res[0]),
    .busy(busy[0]), .done(done[0]), .tt_data(ttd[0]), .tt_valid(tt_valid[0]),
    .tt_ready(tt_ready), .onset_cnt(onset[0]), .sig(sig[0]));

  proj_sweep_sequencer #(.N_IN(8), .LAT(3), .WORD_W(8)) u_dut_lat3 (
    .clk(clk), .rst(rst), .start(start), .pat_o(pat[1]), .res_i(res[1]),
    .busy(busy[1]), .done(done[1]), .tt_data(ttd[1]), .tt_valid(tt_valid[1]),
    .tt_ready(tt_ready), .onset_cnt(onset[1]), .sig(sig[1]));

  int n_checks = 0;
  int n_pass   = 0;
  int ready_pct = 100;

  initial forever begin
    @(negedge clk);
    tt_ready = (int'($urandom_range(0, 99)) < ready_pct);
  end

  // Monitor: accepted words, done pulses, stall stability, double-length done
  logic [7:0] rx [2][RXMAX];
  int   rx_n [2]      = '{0, 0};
  int   dcnt [2]      = '{0, 0};
  int   stall_err [2] = '{0, 0};
  int   dbl_err [2]   = '{0, 0};
  logic prev_stall [2] = '{1'b0, 1'b0};
  logic prev_done  [2] = '{1'b0, 1'b0};
  logic [7:0] prev_data [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        prev_stall[d] <= 1'b0;
        prev_done[d]  <= 1'b0;
      end else begin
        if (tt_valid[d] && tt_ready && rx_n[d] < RXMAX) begin
          rx[d][rx_n[d]] <= ttd[d];
          rx_n[d]        <= rx_n[d] + 1;
        end
        if (prev_stall[d] && (!tt_valid[d] || ttd[d] !== prev_data[d]))
          stall_err[d] <= stall_err[d] + 1;
        if (done[d]) begin
          dcnt[d] <= dcnt[d] + 1;
          if (prev_done[d]) dbl_err[d] <= dbl_err[d] + 1;
        end
        prev_stall[d] <= tt_valid[d] && !tt_ready;
        prev_data[d]  <= ttd[d];
        prev_done[d]  <= done[d];
      end
    end
  end

  // Reference model: truth-table words, onset count and bitwise CRC-16 over pattern order
  logic [7:0]  exp_w [NWORD];
  logic [8:0]  exp_on;
  logic [15:0] exp_sig;
  int b_rx [2];
  int b_dn [2];

  function automatic logic cone_fn(input int mode, input int p);
    logic [7:0] x;
    x = 8'(p);
    case (mode)
      0: return 1'b1;
      1: return x[0];
      2: return x[7];
      3: return ((x[0] & x[1]) | (x[0] & x[2])) ^ (x[3] & x[4] & ~x[5]) ^ (x[6] | x[7]);
      4: return (x[0] & (x[1] | x[2])) ^ (x[3] & x[4] & ~x[5]) ^ ~(~x[6] & ~x[7]);
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_cone(input int mode);
    logic b, fbit;
    for (int p = 0; p < NPAT; p++) begin
      if (mode == 5) cone_tt[p] = 1'($urandom_range(0, 1));
      else cone_tt[p] = cone_fn(mode, p);
    end
    exp_on  = '0;
    exp_sig = 16'hFFFF;
    for (int p = 0; p < NPAT; p++) begin
      b = cone_tt[p];
      exp_w[p / 8][p % 8] = b;
      exp_on  = exp_on + 9'(b);
      fbit    = exp_sig[15] ^ b;
      exp_sig = {exp_sig[14:0], 1'b0} ^ (fbit ? 16'h1021 : 16'h0000);
    end
  endtask

  function automatic int word_errs(input int d, input int base);
    int e;
    e = 0;
    if (rx_n[d] - base != NWORD) e = e + 100;
    for (int i = 0; i < NWORD; i++)
      if (rx[d][base + i] !== exp_w[i]) e = e + 1;
    return e;
  endfunction

  task automatic run_sweep(input int pulse_at, output int cyc0);
    for (int d = 0; d < 2; d++) begin
      b_rx[d] = rx_n[d];
      b_dn[d] = dcnt[d];
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc0 = -1;
    for (int c = 1; c < 6000; c++) begin
      start = (c == pulse_at);
      @(negedge clk);
      if (cyc0 < 0 && dcnt[0] > b_dn[0]) cyc0 = c;
      if (dcnt[0] > b_dn[0] && dcnt[1] > b_dn[1] && busy == 2'b00) break;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({pat[d], busy[d], done[d], tt_valid[d], ttd[d], onset[d], sig[d]} !==
          {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 16'hFFFF})
        $display("FAIL reset_values dut%0d: got pat=%h busy=%b done=%b valid=%b data=%h onset=%0d sig=%h, want zeros and sig=ffff",
                 d, pat[d], busy[d], done[d], tt_valid[d], ttd[d], onset[d], sig[d]);
      else n_pass++;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 4'b0000)
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 00 00", busy, done);
    else n_pass++;
  endtask

  task automatic test_const_one();
    int cyc0, e;
    ready_pct = 100;
    set_cone(0);
    run_sweep(0, cyc0);
    for (int d = 0; d < 2; d++) begin
      e = word_errs(d, b_rx[d]);
      n_checks++;
      if (e != 0) $display("FAIL const1_words dut%0d: %0d errors (got %0d words), want 32 x ff", d, e, rx_n[d] - b_rx[d]);
      else n_pass++;
      n_checks++;
      if (onset[d] !== 9'd256) $display("FAIL const1_onset dut%0d: got %0d want 256", d, onset[d]);
      else n_pass++;
      n_checks++;
      if (dcnt[d] - b_dn[d] != 1 || dbl_err[d] != 0)
        $display("FAIL const1_done dut%0d: got %0d pulses (%0d long), want exactly 1 one-cycle", d, dcnt[d] - b_dn[d], dbl_err[d]);
      else n_pass++;
    end
    n_checks++;
    if (cyc0 < 256 || cyc0 > 300) $display("FAIL const1_throughput: got %0d cycles to done, want 256..300", cyc0);
    else n_pass++;
  endtask

  task automatic test_single_input();
    int cyc0, e;
    for (int m = 1; m <= 2; m++) begin
      set_cone(m);
      run_sweep(0, cyc0);
      for (int d = 0; d < 2; d++) begin
        e = word_errs(d, b_rx[d]);
        n_checks++;
        if (e != 0 || exp_w[0] !== ((m == 1) ? 8'hAA : 8'h00))
          $display("FAIL x%0d_words dut%0d: %0d errors, word0 got %h", (m == 1) ? 0 : 7, d, e, rx[d][b_rx[d]]);
        else n_pass++;
        n_checks++;
        if (onset[d] !== 9'd128) $display("FAIL x%0d_onset dut%0d: got %0d want 128", (m == 1) ? 0 : 7, d, onset[d]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_golden_vs_opt();
    int cyc0, e;
    logic [7:0]  g_w [2][NWORD];
    logic [15:0] g_sig [2];
    logic [8:0]  g_on [2];
    set_cone(3);
    run_sweep(0, cyc0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NWORD; i++) g_w[d][i] = rx[d][b_rx[d] + i];
      g_sig[d] = sig[d];
      g_on[d]  = onset[d];
      n_checks++;
      if (sig[d] !== exp_sig || onset[d] !== exp_on)
        $display("FAIL golden_sig dut%0d: got sig=%h onset=%0d want sig=%h onset=%0d", d, sig[d], onset[d], exp_sig, exp_on);
      else n_pass++;
    end
    set_cone(4);
    run_sweep(0, cyc0);
    for (int d = 0; d < 2; d++) begin
      e = (rx_n[d] - b_rx[d] != NWORD) ? 100 : 0;
      for (int i = 0; i < NWORD; i++)
        if (rx[d][b_rx[d] + i] !== g_w[d][i] || g_w[d][i] !== exp_w[i]) e++;
      n_checks++;
      if (e != 0) $display("FAIL opt_words dut%0d: %0d words differ from golden run", d, e);
      else n_pass++;
      n_checks++;
      if (sig[d] !== g_sig[d] || onset[d] !== g_on[d] || sig[d] !== exp_sig)
        $display("FAIL opt_sig dut%0d: got sig=%h onset=%0d want sig=%h onset=%0d", d, sig[d], onset[d], exp_sig, g_on[d]);
      else n_pass++;
    end
  endtask

  task automatic test_random_ready();
    int cyc0, e, se0, se1, de0, de1;
    se0 = stall_err[0]; se1 = stall_err[1];
    de0 = dbl_err[0];   de1 = dbl_err[1];
    ready_pct = 30;
    set_cone(5);
    run_sweep(0, cyc0);
    ready_pct = 100;
    for (int d = 0; d < 2; d++) begin
      e = word_errs(d, b_rx[d]);
      n_checks++;
      if (e != 0) $display("FAIL rnd_ready_words dut%0d: %0d errors (got %0d words)", d, e, rx_n[d] - b_rx[d]);
      else n_pass++;
      n_checks++;
      if (onset[d] !== exp_on || sig[d] !== exp_sig)
        $display("FAIL rnd_ready_sig dut%0d: got onset=%0d sig=%h want onset=%0d sig=%h", d, onset[d], sig[d], exp_on, exp_sig);
      else n_pass++;
    end
    n_checks++;
    if (stall_err[0] != se0 || stall_err[1] != se1 || dbl_err[0] != de0 || dbl_err[1] != de1)
      $display("FAIL rnd_ready_stall: got %0d/%0d unstable stalls, %0d/%0d long done, want 0",
               stall_err[0] - se0, stall_err[1] - se1, dbl_err[0] - de0, dbl_err[1] - de1);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int cyc0, e;
    bit hit;
    set_cone(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(negedge clk);
      if (pat[0] == 8'd100) hit = 1'b1;
    end
    n_checks++;
    if (!hit) $display("FAIL midrst_reach: pattern 100 not seen, pat=%0d", pat[0]);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({pat[d], busy[d], done[d], tt_valid[d], ttd[d], onset[d], sig[d]} !==
          {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 16'hFFFF})
        $display("FAIL midrst_values dut%0d: got pat=%h busy=%b valid=%b data=%h onset=%0d sig=%h, want reset values",
                 d, pat[d], busy[d], tt_valid[d], ttd[d], onset[d], sig[d]);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_sweep(0, cyc0);
    for (int d = 0; d < 2; d++) begin
      e = word_errs(d, b_rx[d]);
      n_checks++;
      if (e != 0 || onset[d] !== exp_on || sig[d] !== exp_sig)
        $display("FAIL midrst_rerun dut%0d: %0d word errors, onset=%0d sig=%h want onset=%0d sig=%h",
                 d, e, onset[d], sig[d], exp_on, exp_sig);
      else n_pass++;
    end
  endtask

  task automatic test_start_while_busy();
    int cyc0, e;
    set_cone(5);
    run_sweep(40, cyc0);
    for (int d = 0; d < 2; d++) begin
      e = word_errs(d, b_rx[d]);
      n_checks++;
      if (e != 0 || onset[d] !== exp_on || sig[d] !== exp_sig || dcnt[d] - b_dn[d] != 1)
        $display("FAIL busy_start dut%0d: %0d word errors, %0d done pulses, onset=%0d sig=%h want onset=%0d sig=%h",
                 d, e, dcnt[d] - b_dn[d], onset[d], sig[d], exp_on, exp_sig);
      else n_pass++;
    end
  endtask

  task automatic test_start_held();
    bit hit;
    int e;
    set_cone(3);
    for (int d = 0; d < 2; d++) begin
      b_rx[d] = rx_n[d];
      b_dn[d] = dcnt[d];
    end
    @(negedge clk);
    start = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      if (done[0]) hit = 1'b1;
    end
    n_checks++;
    if (!hit || onset[0] !== exp_on) $display("FAIL held_first_done: hit=%0d onset=%0d want %0d", hit, onset[0], exp_on);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || onset[0] !== exp_on || sig[0] !== exp_sig)
      $display("FAIL held_idle: got busy=%b done=%b onset=%0d sig=%h want 0 0 %0d %h",
               busy[0], done[0], onset[0], sig[0], exp_on, exp_sig);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b1 || onset[0] !== 9'd0 || sig[0] !== 16'hFFFF)
      $display("FAIL held_restart: got busy=%b onset=%0d sig=%h want 1 0 ffff", busy[0], onset[0], sig[0]);
    else n_pass++;
    for (int c = 0; c < 2000; c++) begin
      if (dcnt[1] > b_dn[1] && busy[1]) break;
      @(negedge clk);
    end
    start = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (dcnt[0] >= b_dn[0] + 2 && dcnt[1] >= b_dn[1] + 2 && busy == 2'b00) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e = word_errs(d, b_rx[d] + NWORD);
      n_checks++;
      if (e != 0 || dcnt[d] - b_dn[d] != 2 || onset[d] !== exp_on || sig[d] !== exp_sig)
        $display("FAIL held_second dut%0d: %0d word errors, %0d done pulses, onset=%0d sig=%h want 2 pulses onset=%0d sig=%h",
                 d, e, dcnt[d] - b_dn[d], onset[d], sig[d], exp_on, exp_sig);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_single_input();
    test_golden_vs_opt();
    test_random_ready();
    test_mid_reset();
    test_start_while_busy();
    test_start_held();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
